// File: rtl/kul_pkg.sv
// rtl/kul_pkg.sv - shared types, constants and helpers for the sequential Kulkarni multiplier
package kul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int HALF_W = 4;
  localparam int RES_W  = 16;

  // Left shift applied to each quadrant product, indexed by schedule step.
  function automatic logic [3:0] quad_shift(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'd0;
      2'd1:    return 4'd4;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Kulkarni 2x2 block: exact except 3*3, which yields 7 so the result fits 3 bits.
  function automatic logic [3:0] kul2(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'd3 && b == 2'd3) begin
      return 4'd7;
    end
    return {2'b00, a} * {2'b00, b};
  endfunction

endpackage

// File: rtl/kul4.sv
// rtl/kul4.sv - Kulkarni 4x4 approximate multiplier built from four 2x2 blocks
module kul4
  import kul_pkg::*;
(
  input  logic [HALF_W-1:0]   a,
  input  logic [HALF_W-1:0]   b,
  output logic [2*HALF_W-1:0] p
);

  logic [3:0] pp_ll;
  logic [3:0] pp_hl;
  logic [3:0] pp_lh;
  logic [3:0] pp_hh;

  assign pp_ll = kul2(a[1:0], b[1:0]);
  assign pp_hl = kul2(a[3:2], b[1:0]);
  assign pp_lh = kul2(a[1:0], b[3:2]);
  assign pp_hh = kul2(a[3:2], b[3:2]);

  // Worst case 7 + 28 + 28 + 112 = 175, so eight bits never overflow.
  assign p = {4'b0000, pp_ll}
           + {2'b00, pp_hl, 2'b00}
           + {2'b00, pp_lh, 2'b00}
           + {pp_hh, 4'b0000};

endmodule

// File: rtl/kul8_seq_mul.sv
// rtl/kul8_seq_mul.sv - iterative 8x8 approximate multiplier sharing one Kul4 core over four cycles
module kul8_seq_mul
  import kul_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit EXACT_HI_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic                cfg_exact_hi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_y,
  output logic                busy
);

  localparam int PROD_W = 2 * DATA_W;

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          idx_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                cfg_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   y_q;

  logic                accept;
  logic [HALF_W-1:0]   kul_a;
  logic [HALF_W-1:0]   kul_b;
  logic [2*HALF_W-1:0] kul_p;
  logic [2*HALF_W-1:0] exact_hi;
  logic [2*HALF_W-1:0] quad_p;
  logic [PROD_W-1:0]   acc_sum;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = MUL;
      MUL:  if (idx_q == 2'd3) state_d = DONE;
      DONE: if (out_ready) state_d = in_valid ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accepting in DONE requires the sink to take the current result in the same cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      MUL:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    kul_a = a_q[HALF_W-1:0];
    kul_b = b_q[HALF_W-1:0];
    case (idx_q)
      2'd0: begin
        kul_a = a_q[HALF_W-1:0];
        kul_b = b_q[HALF_W-1:0];
      end
      2'd1: begin
        kul_a = a_q[2*HALF_W-1:HALF_W];
        kul_b = b_q[HALF_W-1:0];
      end
      2'd2: begin
        kul_a = a_q[HALF_W-1:0];
        kul_b = b_q[2*HALF_W-1:HALF_W];
      end
      default: begin
        kul_a = a_q[2*HALF_W-1:HALF_W];
        kul_b = b_q[2*HALF_W-1:HALF_W];
      end
    endcase
  end

  kul4 u_kul4 (
    .a (kul_a),
    .b (kul_b),
    .p (kul_p)
  );

  assign exact_hi = {4'b0000, a_q[2*HALF_W-1:HALF_W]} * {4'b0000, b_q[2*HALF_W-1:HALF_W]};
  assign quad_p   = (idx_q == 2'd3 && cfg_q) ? exact_hi : kul_p;
  assign acc_sum  = acc_q + (PROD_W'(quad_p) << quad_shift(idx_q));

  // out_y comes from y_q so it only moves on entry to DONE, not while acc builds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 2'd0;
      a_q   <= '0;
      b_q   <= '0;
      cfg_q <= 1'b0;
      acc_q <= '0;
      y_q   <= '0;
    end else if (accept) begin
      a_q   <= in_a;
      b_q   <= in_b;
      cfg_q <= cfg_exact_hi & EXACT_HI_EN;
      acc_q <= '0;
      idx_q <= 2'd0;
    end else if (state_q == MUL) begin
      acc_q <= acc_sum;
      idx_q <= idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        y_q <= acc_sum;
      end
    end
  end

  assign out_y = y_q;

endmodule
